ilx511b_adc_capture: RTL and testbench

//  Pixel read-back side of the ILX511B CCD path. Consumes the per-pixel conversion strobe and the frame-start

---
 rtl/ilx511b_adc_capture.sv | 190 +++++++++++++++++++
 tb/tb_ilx511b_adc_capture.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ilx511b_adc_capture.sv
// ILX511B pixel read-back: drives a serial SAR ADC (CNV/SCK/SDO), assembles
// MSB-first samples, drops the leading dummy pixels of each frame and streams
// the effective pixels out over a valid/ready handshake.
//
// Handshake: pix_valid rises with pix_data/pix_last already stable; all three
// hold until the rising clock edge on which pix_valid && pix_ready, which is
// the single transfer cycle. pix_valid never drops before that edge except on
// reset or flag_adc_restart.
module ilx511b_adc_capture #(
    parameter int ADC_BITS   = 16,
    parameter int CNV_CYC    = 40,
    parameter int SCK_DIV    = 2,
    parameter int DUMMY_LEAD = 32,
    parameter int VALID_PIX  = 2048
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                flag_adc_restart,
    input  logic                flag_adc_start,
    input  logic                adc_sdo,
    output logic                adc_cnv,
    output logic                adc_sck,
    output logic [ADC_BITS-1:0] pix_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                pix_last,
    output logic                frame_done,
    output logic                overrun,
    output logic [1:0]          dbg_state_o
);

    // Pixel index is 12 bits wide; a frame must fit DUMMY_LEAD+VALID_PIX <= 4096.
    localparam int IDX_W   = 12;
    localparam int CNT_MAX = (CNV_CYC > 2 * SCK_DIV) ? CNV_CYC : 2 * SCK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(ADC_BITS + 1);

    localparam logic [CNT_W-1:0] CNV_LAST    = CNT_W'(CNV_CYC - 1);
    localparam logic [CNT_W-1:0] SCK_RISE    = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(2 * SCK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(ADC_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);
    localparam logic [IDX_W-1:0] DUMMY_IDX   = IDX_W'(DUMMY_LEAD);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DUMMY_LEAD + VALID_PIX - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIT_W-1:0]    bit_q;
    logic [ADC_BITS-1:0] shift_q;
    logic [ADC_BITS-1:0] data_q;
    logic [IDX_W-1:0]    idx_q;
    logic                armed_q;
    logic                cnv_q;
    logic                sck_q;
    logic                valid_q;
    logic                last_q;
    logic                done_q;
    logic                ovr_q;

    // Transfer and overrun qualifiers for the current cycle.
    logic accept_d;
    logic lost_start_d;

    // Decode the handshake transfer and a start strobe arriving while busy.
    always_comb begin
        accept_d     = valid_q && pix_ready;
        lost_start_d = flag_adc_start && (state_q != IDLE);
    end

    // Capture FSM: convert, shift in MSB first, then drop or forward the sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            armed_q <= 1'b0;
            cnv_q   <= 1'b0;
            sck_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flag_adc_restart) begin
                // New frame: abandon whatever is in flight, re-arm from index 0.
                // A start in this same cycle is ignored and does not count as lost.
                state_q <= IDLE;
                cnt_q   <= '0;
                bit_q   <= '0;
                idx_q   <= '0;
                armed_q <= 1'b1;
                cnv_q   <= 1'b0;
                sck_q   <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                if (lost_start_d) begin
                    ovr_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        // Starts while disarmed (before restart or after the frame) are dropped silently.
                        if (flag_adc_start && armed_q) begin
                            state_q <= CONV;
                            cnv_q   <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    CONV: begin
                        if (cnt_q == CNV_LAST) begin
                            state_q <= SHIFT;
                            cnv_q   <= 1'b0;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    SHIFT: begin
                        // SDO is taken on the same edge that raises SCK.
                        if (cnt_q == SCK_RISE) begin
                            sck_q   <= 1'b1;
                            shift_q <= {shift_q[ADC_BITS-2:0], adc_sdo};
                        end
                        if (cnt_q == PERIOD_LAST) begin
                            sck_q <= 1'b0;
                            cnt_q <= '0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= STORE;
                            end else begin
                                bit_q <= bit_q + BIT_ONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    STORE: begin
                        if (!valid_q) begin
                            if (idx_q < DUMMY_IDX) begin
                                idx_q   <= idx_q + IDX_ONE;
                                state_q <= IDLE;
                            end else begin
                                valid_q <= 1'b1;
                                data_q  <= shift_q;
                                last_q  <= (idx_q == LAST_IDX);
                            end
                        end else if (accept_d) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= IDLE;
                            if (last_q) begin
                                // Frame complete: no wrap, wait for the next restart.
                                idx_q   <= '0;
                                armed_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IDX_ONE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign adc_cnv     = cnv_q;
    assign adc_sck     = sck_q;
    assign pix_data    = data_q;
    assign pix_valid   = valid_q;
    assign pix_last    = last_q;
    assign frame_done  = done_q;
    assign overrun     = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ilx511b_adc_capture.sv
// Bench for ilx511b_adc_capture: ADC behavioural model on CNV/SCK/SDO, a
// negedge handshake monitor, and one task per scenario.
module tb_ilx511b_adc_capture;

  localparam int ADC_BITS   = 16;
  localparam int CNV_CYC    = 40;
  localparam int SCK_DIV    = 2;
  localparam int DUMMY_LEAD = 32;
  localparam int VALID_PIX  = 64;
  localparam int FRAME_PIX  = DUMMY_LEAD + VALID_PIX;
  localparam int PIX_LAT    = 1 + CNV_CYC + 2 * SCK_DIV * ADC_BITS + 1;

  logic                sys_clk;
  logic                sys_rst_n;
  logic                flag_adc_restart;
  logic                flag_adc_start;
  logic                adc_sdo;
  logic                adc_cnv;
  logic                adc_sck;
  logic [ADC_BITS-1:0] pix_data;
  logic                pix_valid;
  logic                pix_ready;
  logic                pix_last;
  logic                frame_done;
  logic                overrun;
  logic [1:0]          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ilx511b_adc_capture #(
    .ADC_BITS  (ADC_BITS),
    .CNV_CYC   (CNV_CYC),
    .SCK_DIV   (SCK_DIV),
    .DUMMY_LEAD(DUMMY_LEAD),
    .VALID_PIX (VALID_PIX)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .flag_adc_restart(flag_adc_restart),
    .flag_adc_start  (flag_adc_start),
    .adc_sdo         (adc_sdo),
    .adc_cnv         (adc_cnv),
    .adc_sck         (adc_sck),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_last        (pix_last),
    .frame_done      (frame_done),
    .overrun         (overrun),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc = cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- ADC model ----------------
  // Each conversion produces a new word (random, or base+n since restart),
  // presented MSB first; the next bit appears after each SCK rise.
  bit                  fixed_mode = 1'b0;
  logic [ADC_BITS-1:0] fixed_base = '0;
  logic [ADC_BITS-1:0] sdo_word   = '0;
  logic [ADC_BITS-1:0] conv_log[$];

  always @(posedge adc_cnv) begin
    logic [ADC_BITS-1:0] w;
    if (fixed_mode) w = fixed_base + ADC_BITS'(conv_log.size());
    else            w = ADC_BITS'($urandom_range(0, 65535));
    conv_log.push_back(w);
    sdo_word = w;
  end
  always @(posedge adc_sck) sdo_word = sdo_word << 1;
  assign adc_sdo = sdo_word[ADC_BITS-1];

  // ---------------- monitor / scoreboard observations ----------------
  logic [ADC_BITS-1:0] acc_data_q[$];
  logic                acc_last_q[$];
  int                  acc_cyc_q[$];
  int                  rise_cyc_q[$];
  int                  fd_cyc_q[$];
  int                  start_cyc_q[$];
  logic [ADC_BITS-1:0] exp_q[$];

  logic                prev_valid = 1'b0;
  logic                prev_acc   = 1'b0;
  logic                prev_rst   = 1'b0;
  logic [ADC_BITS-1:0] prev_data  = '0;

  always @(negedge sys_clk) begin
    // A pending pixel must hold until its transfer edge unless a restart/reset intervened.
    if (prev_valid && !prev_acc && !prev_rst && sys_rst_n) begin
      n_tests++;
      if (pix_valid !== 1'b1 || pix_data !== prev_data) begin
        n_fail++;
        $display("FAIL hold_stable @%0d: valid=%b data=%h required valid=1 data=%h",
                 cyc, pix_valid, pix_data, prev_data);
      end
    end
    if (sys_rst_n && pix_valid && !prev_valid) rise_cyc_q.push_back(cyc);
    if (sys_rst_n && pix_valid && pix_ready) begin
      acc_data_q.push_back(pix_data);
      acc_last_q.push_back(pix_last);
      acc_cyc_q.push_back(cyc);
    end
    if (frame_done) fd_cyc_q.push_back(cyc);
    prev_valid = pix_valid;
    prev_acc   = pix_valid && pix_ready;
    prev_rst   = flag_adc_restart;
    prev_data  = pix_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_cyc_q.push_back(cyc);
    flag_adc_start = 1'b1;
    tick(1);
    flag_adc_start = 1'b0;
  endtask

  task automatic pulse_restart();
    flag_adc_restart = 1'b1;
    tick(1);
    flag_adc_restart = 1'b0;
    conv_log.delete();
  endtask

  task automatic clear_obs();
    acc_data_q.delete();
    acc_last_q.delete();
    acc_cyc_q.delete();
    rise_cyc_q.delete();
    fd_cyc_q.delete();
    start_cyc_q.delete();
    conv_log.delete();
    exp_q.delete();
  endtask

  task automatic run_pixels(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      pulse_start();
      tick(PIX_LAT + int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic wait_sck_high(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (adc_sck === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (pix_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Reference: which conversions of a frame become pixels, and which is last.
  task automatic build_expected(input int n_conv);
    exp_q.delete();
    for (int i = DUMMY_LEAD; i < n_conv && i < FRAME_PIX; i++) exp_q.push_back(conv_log[i]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit found;
    sys_rst_n = 1'b0;
    tick(3);
    @(negedge sys_clk);
    n_tests++;
    if ({adc_cnv, adc_sck, pix_valid, pix_last, frame_done, overrun, pix_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%b required all 0",
               {adc_cnv, adc_sck, pix_valid, pix_last, frame_done, overrun, pix_data});
    end
    tick(1);
    sys_rst_n = 1'b1;
    tick(2);
    pulse_restart();
    clear_obs();
    pulse_start();
    tick(5);
    pulse_start();
    wait_sck_high(found);
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_sck_seen: sck high not observed required 1");
    end
    #1 sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({adc_cnv, adc_sck, pix_valid, pix_last, frame_done, overrun, pix_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%b required all 0",
               {adc_cnv, adc_sck, pix_valid, pix_last, frame_done, overrun, pix_data});
    end
    tick(2);
    sys_rst_n = 1'b1;
    tick(1);
    clear_obs();
    run_pixels(3, 0);
    n_tests++;
    if (conv_log.size() != 0 || acc_data_q.size() != 0 || rise_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_disarmed: conversions=%0d accepts=%0d required 0 0",
               conv_log.size(), acc_data_q.size());
    end
  endtask

  task automatic test_dummy_lead();
    int lat;
    pix_ready  = 1'b1;
    fixed_mode = 1'b1;
    fixed_base = 16'hA5C3;
    pulse_restart();
    clear_obs();
    run_pixels(DUMMY_LEAD + 2, 2);
    n_tests++;
    if (acc_data_q.size() != 2 || rise_cyc_q.size() != 2) begin
      n_fail++;
      $display("FAIL dummy_count: accepts=%0d rises=%0d required 2 2",
               acc_data_q.size(), rise_cyc_q.size());
    end
    n_tests++;
    if (acc_data_q.size() < 2 || acc_data_q[0] !== 16'hA5E3 || acc_data_q[1] !== 16'hA5E4) begin
      n_fail++;
      $display("FAIL dummy_data: got %h %h required a5e3 a5e4",
               acc_data_q.size() > 0 ? acc_data_q[0] : 16'h0,
               acc_data_q.size() > 1 ? acc_data_q[1] : 16'h0);
    end
    n_tests++;
    if (acc_last_q.size() < 2 || acc_last_q[0] !== 1'b0 || acc_last_q[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL dummy_last: pix_last set on a non-final pixel required 0");
    end
    lat = (rise_cyc_q.size() > 0 && start_cyc_q.size() > DUMMY_LEAD)
          ? rise_cyc_q[0] - start_cyc_q[DUMMY_LEAD] : -1;
    n_tests++;
    if (lat != PIX_LAT) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles required %0d", lat, PIX_LAT);
    end
    fixed_mode = 1'b0;
  endtask

  task automatic test_full_frame();
    int nlast;
    int n_conv;
    pix_ready  = 1'b1;
    fixed_mode = 1'b0;
    pulse_restart();
    clear_obs();
    run_pixels(FRAME_PIX, 3);
    build_expected(conv_log.size());
    n_tests++;
    if (acc_data_q.size() != VALID_PIX || conv_log.size() != FRAME_PIX) begin
      n_fail++;
      $display("FAIL frame_count: accepts=%0d conversions=%0d required %0d %0d",
               acc_data_q.size(), conv_log.size(), VALID_PIX, FRAME_PIX);
    end
    for (int i = 0; i < VALID_PIX; i++) begin
      n_tests++;
      if (i >= acc_data_q.size() || i >= exp_q.size() || acc_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL frame_data[%0d]: got %h required %h", i,
                 i < acc_data_q.size() ? acc_data_q[i] : 16'h0,
                 i < exp_q.size() ? exp_q[i] : 16'h0);
      end
    end
    nlast = 0;
    foreach (acc_last_q[i]) if (acc_last_q[i] === 1'b1) nlast++;
    n_tests++;
    if (nlast != 1 || acc_last_q.size() == 0 || acc_last_q[acc_last_q.size()-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_last: %0d pixels flagged last required 1 on the final pixel", nlast);
    end
    n_tests++;
    if (fd_cyc_q.size() != 1 || acc_cyc_q.size() == 0 ||
        fd_cyc_q[0] != acc_cyc_q[acc_cyc_q.size()-1] + 1) begin
      n_fail++;
      $display("FAIL frame_done: pulses=%0d at %0d required 1 at %0d", fd_cyc_q.size(),
               fd_cyc_q.size() > 0 ? fd_cyc_q[0] : -1,
               acc_cyc_q.size() > 0 ? acc_cyc_q[acc_cyc_q.size()-1] + 1 : -1);
    end
    n_conv = conv_log.size();
    run_pixels(1, 0);
    n_tests++;
    if (conv_log.size() != n_conv || acc_data_q.size() != VALID_PIX || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_after_end: conversions=%0d accepts=%0d overrun=%b required %0d %0d 0",
               conv_log.size(), acc_data_q.size(), overrun, n_conv, VALID_PIX);
    end
  endtask

  task automatic test_stall();
    bit                  found;
    logic [ADC_BITS-1:0] held;
    int                  unstable;
    int                  ready_cyc;
    pix_ready = 1'b1;
    pulse_restart();
    clear_obs();
    run_pixels(DUMMY_LEAD, 0);
    pix_ready = 1'b0;
    pulse_start();
    wait_valid(found);
    held = pix_data;
    build_expected(conv_log.size());
    n_tests++;
    if (!found || exp_q.size() != 1 || held !== exp_q[0]) begin
      n_fail++;
      $display("FAIL stall_data: valid_seen=%b data=%h required 1 %h", found, held,
               exp_q.size() > 0 ? exp_q[0] : 16'h0);
    end
    unstable = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (pix_valid !== 1'b1 || pix_data !== held) unstable++;
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d unstable cycles required 0", unstable);
    end
    tick(1);
    pix_ready = 1'b1;
    ready_cyc = cyc;
    @(negedge sys_clk);
    @(negedge sys_clk);
    n_tests++;
    if (acc_data_q.size() != 1 || acc_cyc_q[0] != ready_cyc || acc_data_q[0] !== held ||
        pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_accept: accepts=%0d at %0d valid=%b required 1 at %0d valid=0",
               acc_data_q.size(), acc_cyc_q.size() > 0 ? acc_cyc_q[0] : -1, pix_valid, ready_cyc);
    end
  endtask

  task automatic test_overrun();
    bit                  found;
    logic [ADC_BITS-1:0] held;
    pix_ready = 1'b1;
    pulse_restart();
    clear_obs();
    run_pixels(DUMMY_LEAD, 0);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_idle: got %b required 0", overrun);
    end
    pix_ready = 1'b0;
    pulse_start();
    tick(10);
    pulse_start();
    @(negedge sys_clk);
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_conv: got %b required 1", overrun);
    end
    wait_valid(found);
    held = pix_data;
    tick(1);
    pulse_start();
    tick(3);
    @(negedge sys_clk);
    n_tests++;
    if (!found || pix_valid !== 1'b1 || pix_data !== held || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_stall: valid=%b data=%h overrun=%b required 1 %h 1",
               pix_valid, pix_data, overrun, held);
    end
    tick(1);
    pix_ready = 1'b1;
    tick(3);
    build_expected(conv_log.size());
    n_tests++;
    if (acc_data_q.size() != 1 || conv_log.size() != DUMMY_LEAD + 1 || exp_q.size() != 1 ||
        acc_data_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overrun_pixel: accepts=%0d conversions=%0d data=%h required 1 %0d %h",
               acc_data_q.size(), conv_log.size(),
               acc_data_q.size() > 0 ? acc_data_q[0] : 16'h0, DUMMY_LEAD + 1,
               exp_q.size() > 0 ? exp_q[0] : 16'h0);
    end
    pulse_restart();
    @(negedge sys_clk);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b required 0", overrun);
    end
  endtask

  task automatic test_restart_shift();
    bit found;
    int n_acc;
    pix_ready = 1'b1;
    pulse_restart();
    clear_obs();
    run_pixels(40, 1);
    n_tests++;
    if (acc_data_q.size() != 40 - DUMMY_LEAD) begin
      n_fail++;
      $display("FAIL restart_pre: accepts=%0d required %0d", acc_data_q.size(), 40 - DUMMY_LEAD);
    end
    n_acc = acc_data_q.size();
    pulse_start();
    wait_sck_high(found);
    tick(1);
    flag_adc_restart = 1'b1;
    tick(1);
    flag_adc_restart = 1'b0;
    @(negedge sys_clk);
    n_tests++;
    if (!found || {adc_sck, adc_cnv, pix_valid, pix_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL restart_outputs: sck_seen=%b sck/cnv/valid/last=%b required 1 0000",
               found, {adc_sck, adc_cnv, pix_valid, pix_last});
    end
    tick(PIX_LAT + 10);
    n_tests++;
    if (acc_data_q.size() != n_acc) begin
      n_fail++;
      $display("FAIL restart_no_emit: accepts=%0d required %0d", acc_data_q.size(), n_acc);
    end
    clear_obs();
    run_pixels(DUMMY_LEAD + 1, 2);
    build_expected(conv_log.size());
    n_tests++;
    if (acc_data_q.size() != 1 || exp_q.size() != 1 || acc_data_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL restart_index0: accepts=%0d data=%h required 1 %h", acc_data_q.size(),
               acc_data_q.size() > 0 ? acc_data_q[0] : 16'h0,
               exp_q.size() > 0 ? exp_q[0] : 16'h0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sys_rst_n        = 1'b0;
    flag_adc_restart = 1'b0;
    flag_adc_start   = 1'b0;
    pix_ready        = 1'b1;
    test_reset();
    test_dummy_lead();
    test_full_frame();
    test_stall();
    test_overrun();
    test_restart_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
